// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encodings,
// owner IDs, and the strobe/data constants used by the arbiter and IF buffer.
// No logic, so no latency or backpressure of its own.
package mem_arbiter_pkg;

  // Arbiter FSM states. The 2-bit encoding leaves one spare value, which
  // the FSM treats as IDLE.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  // Which requester owns the transaction currently on the RAM port.
  typedef enum logic {
    ARB_OWN_IF  = 1'b0,
    ARB_OWN_MEM = 1'b1
  } arb_owner_e;

  localparam logic        ChipEnable   = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

endpackage

// File: rtl/mem_arb_ifbuf.sv
// One-entry instruction-fetch buffer {valid, addr, data} for the arbiter.
// Latency: fill/invalidate take effect next cycle; lookup is combinational.
// Backpressure: none; the arbiter decides when lookup results are used.
// Only compiled when IF_BUF_EN is defined.
// Ports: fill_i/fill_addr_i/fill_data_i load the entry; inv_i with
// inv_waddr_i (word address) clears it on a matching store; lookup_addr_i
// is compared in full against the entry, giving match_o and data_o.
`ifdef IF_BUF_EN
module mem_arb_ifbuf
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inv_i,
  input  logic [ADDR_W-3:0] inv_waddr_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              match_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      addr_d  = fill_addr_i;
      data_d  = fill_data_i;
    end else if (inv_i && (inv_waddr_i == addr_q[ADDR_W-1:2])) begin
      // Any store touching the buffered word makes its copy stale,
      // whatever the byte enables.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= DATA_W'(ZeroWord);
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign match_o = valid_q && (lookup_addr_i == addr_q);
  assign data_o  = data_q;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch (read-only) and MEM stage, MEM first.
// Latency: hit one cycle after ram_ack_i (2 cycles with zero-wait RAM); IF buffer hit 0.
// Backpressure: requesters hold ce/addr until their hit; one transaction outstanding.
// Optional macro IF_BUF_EN adds a one-entry IF read buffer (mem_arb_ifbuf).
// Ports: clk/rst (synchronous, active-high); if_* fetch requester; mem_*
// load/store requester; ram_* RAM controller side; busy_o = FSM not IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_ce_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_data_o,
  output logic                if_hit_o,
  input  logic                mem_ce_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic                mem_hit_o,
  output logic                ram_req_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W/8-1:0] ram_sel_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic [DATA_W-1:0]   ram_rdata_i,
  input  logic                ram_ack_i,
  output logic                busy_o
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              we_q,    we_d;
  logic [SEL_W-1:0]  sel_q,   sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              if_done_hit;
  logic              mem_done_hit;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;

`ifdef IF_BUF_EN
  logic buf_match;
  logic buf_fill;
  logic buf_inv;

  // Fill from the read register in DONE, even when the requester has
  // moved on: the data is still correct for the latched address.
  assign buf_fill = (state_q == ARB_DONE) && (owner_q == ARB_OWN_IF);
  // A store is granted in IDLE whenever mem_ce_i is high, so this is the
  // only point where the buffer can go stale.
  assign buf_inv  = (state_q == ARB_IDLE) && (mem_ce_i == ChipEnable) &&
                    (mem_we_i == WriteEnable);

  mem_arb_ifbuf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ifbuf (
    .clk          (clk),
    .rst          (rst),
    .fill_i       (buf_fill),
    .fill_addr_i  (addr_q),
    .fill_data_i  (rdata_q),
    .inv_i        (buf_inv),
    .inv_waddr_i  (mem_addr_i[ADDR_W-1:2]),
    .lookup_addr_i(if_addr_i),
    .match_o      (buf_match),
    .data_o       (buf_data)
  );

  // MEM keeps priority even over a free buffer hit.
  assign buf_hit = (state_q == ARB_IDLE) && (if_ce_i == ChipEnable) &&
                   (mem_ce_i != ChipEnable) && buf_match;
`else
  assign buf_hit  = 1'b0;
  assign buf_data = DATA_W'(ZeroWord);
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    if_done_hit  = 1'b0;
    mem_done_hit = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (mem_ce_i == ChipEnable) begin
          owner_d = ARB_OWN_MEM;
          addr_d  = mem_addr_i;
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          wdata_d = mem_data_i;
          state_d = ARB_BUSY;
        end else if ((if_ce_i == ChipEnable) && !buf_hit) begin
          owner_d = ARB_OWN_IF;
          addr_d  = if_addr_i;
          we_d    = WriteDisable;
          sel_d   = '1;
          wdata_d = DATA_W'(ZeroWord);
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (ram_ack_i) begin
          if (we_q != WriteEnable) rdata_d = ram_rdata_i;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        // Hit only if the requester still wants this exact access; a
        // flushed or redirected request simply never sees a hit.
        state_d = ARB_IDLE;
        if (owner_q == ARB_OWN_IF) begin
          if_done_hit  = (if_ce_i == ChipEnable) && (if_addr_i == addr_q);
        end else begin
          mem_done_hit = (mem_ce_i == ChipEnable) && (mem_addr_i == addr_q) &&
                         (mem_we_i == we_q);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWN_IF;
      addr_q  <= '0;
      we_q    <= WriteDisable;
      sel_q   <= '0;
      wdata_q <= DATA_W'(ZeroWord);
      rdata_q <= DATA_W'(ZeroWord);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_req_o   = (state_q == ARB_BUSY);
  assign ram_we_o    = we_q;
  assign ram_addr_o  = addr_q;
  assign ram_sel_o   = sel_q;
  assign ram_wdata_o = wdata_q;

  assign if_hit_o    = if_done_hit | buf_hit;
  assign if_data_o   = buf_hit ? buf_data : rdata_q;
  assign mem_hit_o   = mem_done_hit;
  assign mem_data_o  = rdata_q;
  assign busy_o      = (state_q != ARB_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single word-wide RAM port between instruction fetch (IF, read-only) and the MEM stage (load/store).
- Sits between the IF/MEM pipeline stages and the RAM controller. Returns per-requester hit pulses; each requester holds its request and stalls until it sees its hit.
- Fixed priority: MEM above IF, so an in-flight load/store is never starved by fetch.

Parameters:
- ADDR_W, 32, address width of requesters and RAM port.
- DATA_W, 32, data width; byte-select width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_ce_i  in  1  IF read request
- if_addr_i  in  ADDR_W  IF word address
- if_data_o  out  DATA_W  IF read data, valid while if_hit_o=1
- if_hit_o  out  1  IF transaction complete
- mem_ce_i  in  1  MEM request
- mem_we_i  in  1  1=store, 0=load
- mem_addr_i  in  ADDR_W  MEM address
- mem_sel_i  in  DATA_W/8  byte enables
- mem_data_i  in  DATA_W  store data
- mem_data_o  out  DATA_W  load data, valid while mem_hit_o=1
- mem_hit_o  out  1  MEM transaction complete
- ram_req_o  out  1  RAM request, held until ack
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM address
- ram_sel_o  out  DATA_W/8  RAM byte enables
- ram_wdata_o  out  DATA_W  RAM write data
- ram_rdata_i  in  DATA_W  RAM read data, valid with ack
- ram_ack_i  in  1  RAM completion, single-cycle pulse
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: rst is synchronous, active-high.
  - On reset, state=IDLE and all outputs are 0.
  - An in-flight transaction is abandoned. ram_req_o drops at the reset edge.
  - A late ram_ack_i is ignored in IDLE.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If mem_ce_i=1, grant MEM; else if if_ce_i=1, grant IF.
  - On grant, register owner, addr, we, sel and wdata. Go to BUSY.
  - For IF grants: we=0, sel=all-ones.
- BUSY:
  - ram_req_o=1; ram_* outputs driven from the registers and stable throughout.
  - On ram_ack_i=1: latch ram_rdata_i (reads only), go to DONE.
  - Wait is unbounded.
- DONE:
  - ram_req_o=0.
  - Owner's hit is asserted for exactly one cycle only if the owner's ce_i is still 1, its addr_i equals the latched addr, and (MEM only) we_i equals the latched we.
  - Otherwise the result is dropped silently (flush or redirect).
  - Always return to IDLE next cycle. A new arbitration happens in IDLE, so no back-to-back issue from DONE.
- Latency: with a zero-wait RAM (ack in the first BUSY cycle), hit is 2 cycles after the request is first seen in IDLE. In general, hit = ack cycle + 1.
- Data outputs hold the last latched value when hit=0. if_data_o and mem_data_o share one data register.
- Stores: mem_hit_o still pulses in DONE; mem_data_o is don't-care.
- Simultaneous IF+MEM in IDLE: MEM wins. IF waits, fetch stalls.
- A request arriving while BUSY or DONE waits; nothing is queued.
- Only one transaction is outstanding at any time.

Optional Feature:
- Macro IF_BUF_EN.
- Defined: one-entry IF buffer holding {valid, addr, data}.
  - Filled in DONE on any completed IF read.
  - If if_ce_i=1, if_addr_i matches the buffer, valid=1 and the state is IDLE: if_hit_o=1 combinationally in that cycle with the buffered data. No RAM transaction is issued.
  - MEM still has priority: if mem_ce_i=1 in that cycle, the IF buffer hit is suppressed.
  - Invalidated by reset, or by a MEM store granted to the same word address (addr[ADDR_W-1:2] compare).
- Undefined: no buffer. Every IF request goes to RAM; if_hit_o is registered only.

Decomposition:
- Shared defines include: state encodings (ARB_IDLE/ARB_BUSY/ARB_DONE), owner IDs (ARB_OWN_IF/ARB_OWN_MEM), ChipEnable/WriteEnable constants, ZeroWord.
- Sub-module mem_arb_ifbuf: one-entry IF buffer with fill, lookup and invalidate. Instantiated only under IF_BUF_EN.

Test Plan:
- Zero-wait load: mem_ce=1, we=0, addr=0x100, ack in first BUSY cycle with rdata=0xDEADBEEF -> ram_req high 1 cycle, mem_hit=1 and mem_data=0xDEADBEEF exactly 2 cycles after request.
- Contention: if_ce=1 addr=0x40 and mem_ce=1 store addr=0x200 data=0x12345678 sel=0xF in the same cycle -> RAM sees the store first. IF issued in the following IDLE; if_hit follows its own ack+1.
- Wait states: IF read addr=0x80, ack delayed 5 cycles -> ram_addr/ram_req stable all 5 cycles; if_hit 1 cycle after ack.
- Flush: IF read addr=0x80, if_addr changes to 0x300 before DONE -> no if_hit for 0x80. 0x300 is issued next in IDLE.
- Reset mid-BUSY: assert rst while waiting for ack, then ack arrives -> ram_req=0 after the reset edge, no hit, state IDLE.
- IF_BUF_EN:
  - Read 0x40 twice -> second read gives if_hit in the same cycle, no ram_req.
  - Store to 0x40, then read 0x40 -> buffer miss, RAM read issued.
